// File: rtl/fft_reorder_pkg.sv
// Shared types and helpers for the FFT reorder buffer: state encoding, widths,
// and the bit-reverse address function also used by the FFT address generator.
package fft_reorder_pkg;

    localparam int DW     = 16;
    localparam int AW     = 8;
    localparam int LOGMIN = 4;

    typedef enum logic [1:0] {
        ST_WRITE = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Reverse all AW bits, then shift the reversed low field down to bit 0.
    // Upper bits of v must be 0 (index < N), so the result's upper bits are 0.
    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] v, input logic [3:0] log2n);
        logic [AW-1:0] r;
        r = {<<{v}};
        return r >> (4'(AW) - log2n);
    endfunction

    function automatic logic [3:0] clamp_log2n(input logic [3:0] c);
        return (c < 4'(LOGMIN) || c > 4'(AW)) ? 4'(AW) : c;
    endfunction

    function automatic logic [AW-1:0] last_idx(input logic [3:0] log2n);
        logic [AW:0] t;
        t = ((AW+1)'(1) << log2n) - (AW+1)'(1);
        return t[AW-1:0];
    endfunction

endpackage

// File: rtl/fft_reorder_ctrl_if.sv
// Stream-in, stream-out and SRAM-side signals of the reorder controller.
interface fft_reorder_ctrl_if;
    import fft_reorder_pkg::*;

    logic [3:0]    cfg_log2n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          err_len;
    logic          sram_ce;
    logic          sram_rw;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din;
    logic [DW-1:0] sram_dout;

    modport master (
        input  cfg_log2n, in_valid, in_data, in_last, out_ready, sram_dout,
        output in_ready, out_valid, out_data, out_last, err_len,
               sram_ce, sram_rw, sram_addr, sram_din
    );

    modport slave (
        output cfg_log2n, in_valid, in_data, in_last, out_ready, sram_dout,
        input  in_ready, out_valid, out_data, out_last, err_len,
               sram_ce, sram_rw, sram_addr, sram_din
    );

endinterface

// File: rtl/fft_reorder_ofifo2.sv
// Two-entry valid/ready output FIFO; caller guarantees no push when full
// and no pop when empty.
module fft_reorder_ofifo2 #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic [1:0]   cnt_o
);

    logic [W-1:0] mem_q [2];
    logic         wptr_q;
    logic         rptr_q;
    logic [1:0]   cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= 1'b0;
            rptr_q <= 1'b0;
            cnt_q  <= 2'd0;
        end else begin
            if (push_i) wptr_q <= ~wptr_q;
            if (pop_i)  rptr_q <= ~rptr_q;
            cnt_q <= cnt_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wptr_q] <= push_data_i;
    end

    assign valid_o = (cnt_q != 2'd0);
    assign data_o  = mem_q[rptr_q];
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/fft_reorder_ctrl.sv
// Reorder controller: writes a natural-order frame to the single-port SRAM at
// bit-reversed addresses, then streams it back out sequentially.
module fft_reorder_ctrl
    import fft_reorder_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    fft_reorder_ctrl_if.master bus
);

    state_e        state_q, state_d;
    logic [AW-1:0] wcnt_q, wcnt_d;
    logic [AW-1:0] rcnt_q, rcnt_d;
    logic [3:0]    log2n_q, log2n_d;
    logic          inflight_q, inflight_d;
    logic          rd_last_q, rd_last_d;

    logic [3:0]    log2n_cur;
    logic [AW-1:0] last_w, last_r;
    logic          wr_hs, rd_issue, pop;
    logic          fifo_valid;
    logic [DW:0]   fifo_data;
    logic [1:0]    fifo_cnt;
    logic          credit_ok;

    // The first sample of a frame uses the live config so its address is right.
    assign log2n_cur = (wcnt_q == '0) ? clamp_log2n(bus.cfg_log2n) : log2n_q;
    assign last_w    = last_idx(log2n_cur);
    assign last_r    = last_idx(log2n_q);

    assign wr_hs = (state_q == ST_WRITE) && bus.in_valid;
    assign pop   = fifo_valid && bus.out_ready;

    // A read lands in the FIFO two cycles after issue; counting this cycle's
    // pop as freed space keeps one sample per clock without overflow.
    assign credit_ok = ({1'b0, fifo_cnt} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop});
    assign rd_issue  = (state_q == ST_READ) && credit_ok;

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        rcnt_d     = rcnt_q;
        log2n_d    = log2n_q;
        inflight_d = rd_issue;
        rd_last_d  = rd_issue && (rcnt_q == last_r);
        case (state_q)
            ST_WRITE: begin
                if (wr_hs) begin
                    wcnt_d = wcnt_q + 1'b1;
                    if (wcnt_q == '0) log2n_d = log2n_cur;
                    if (wcnt_q == last_w) begin
                        wcnt_d  = '0;
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ: begin
                if (rd_issue) begin
                    rcnt_d = rcnt_q + 1'b1;
                    if (rcnt_q == last_r) begin
                        rcnt_d  = '0;
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && fifo_data[DW] && fifo_cnt == 2'd1 && !inflight_q)
                    state_d = ST_WRITE;
            end
            default: state_d = ST_WRITE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_WRITE;
            wcnt_q     <= '0;
            rcnt_q     <= '0;
            log2n_q    <= 4'(AW);
            inflight_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
            rcnt_q     <= rcnt_d;
            log2n_q    <= log2n_d;
            inflight_q <= inflight_d;
            rd_last_q  <= rd_last_d;
        end
    end

    fft_reorder_ofifo2 #(.W(DW + 1)) u_ofifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (inflight_q),
        .push_data_i ({rd_last_q, bus.sram_dout}),
        .pop_i       (pop),
        .valid_o     (fifo_valid),
        .data_o      (fifo_data),
        .cnt_o       (fifo_cnt)
    );

    assign bus.in_ready  = (state_q == ST_WRITE);
    assign bus.err_len   = wr_hs && (bus.in_last != (wcnt_q == last_w));
    assign bus.sram_ce   = wr_hs || rd_issue;
    assign bus.sram_rw   = wr_hs;
    assign bus.sram_addr = wr_hs ? bitrev(wcnt_q, log2n_cur) : rcnt_q;
    assign bus.sram_din  = bus.in_data;
    assign bus.out_valid = fifo_valid;
    assign bus.out_data  = fifo_data[DW-1:0];
    assign bus.out_last  = fifo_valid && fifo_data[DW];

endmodule

// File: tb/tb_fft_reorder_ctrl.sv
// Bench for fft_reorder_ctrl with a behavioural single-port SRAM and a
// scoreboard of expected output samples.
module tb_fft_reorder_ctrl;

    logic clk;
    logic rst_n;
    fft_reorder_ctrl_if bus();

    fft_reorder_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [15:0] sram [256];
    always @(posedge clk) begin
        if (bus.sram_ce) begin
            if (bus.sram_rw) sram[bus.sram_addr] <= bus.sram_din;
            else             bus.sram_dout <= sram[bus.sram_addr];
        end
    end

    int          total, bad;
    logic [16:0] sbq [$];
    int          pops, run, last_run;
    bit          rnd_rdy;
    bit          stall_prev;
    logic [16:0] held;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rev(input int v, input int l2);
        int r;
        r = 0;
        for (int i = 0; i < l2; i++) r = (r << 1) | ((v >> i) & 1);
        return r;
    endfunction

    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: scoreboard compare, hold-while-stalled, valid run length.
    initial begin
        pops = 0; run = 0; last_run = 0; stall_prev = 0; held = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_prev = 0;
                run = 0;
            end else begin
                if (stall_prev) begin
                    chk("hold_valid", bus.out_valid, 1);
                    chk("hold_data", {bus.out_last, bus.out_data}, held);
                end
                if (bus.out_valid) run++;
                else run = 0;
                if (bus.out_valid && bus.out_ready) begin
                    chk("sb_avail", 32'(sbq.size() != 0), 1);
                    if (sbq.size() != 0) begin
                        chk("out", {bus.out_last, bus.out_data}, sbq.pop_front());
                    end
                    pops++;
                    if (bus.out_last) last_run = run;
                end
                stall_prev = bus.out_valid && !bus.out_ready;
                held = {bus.out_last, bus.out_data};
            end
        end
    end

    // Called at posedge+1 with in_ready high; returns at posedge+1.
    task automatic send_frame(input logic [3:0] cfg0, input logic [3:0] cfg1,
                              input int last_pos, input bit rnd);
        int l2, n;
        logic [15:0] d [256];
        l2 = (cfg0 >= 4'd4 && cfg0 <= 4'd8) ? int'(cfg0) : 8;
        n  = 1 << l2;
        for (int k = 0; k < n; k++) d[k] = rnd ? 16'($urandom) : 16'(k);
        for (int j = 0; j < n; j++) sbq.push_back({j == n - 1, d[rev(j, l2)]});
        for (int k = 0; k < n; k++) begin
            bus.cfg_log2n = (k == 0) ? cfg0 : cfg1;
            bus.in_valid  = 1'b1;
            bus.in_data   = d[k];
            bus.in_last   = (k == last_pos);
            @(negedge clk);
            chk("in_ready", bus.in_ready, 1);
            chk("err_len", bus.err_len, 32'((k == last_pos) != (k == n - 1)));
            chk("wr_addr", {bus.sram_ce, bus.sram_rw, bus.sram_addr}, {2'b11, 8'(rev(k, l2))});
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_done();
        int c;
        c = 0;
        while ((sbq.size() != 0 || !bus.in_ready) && c < 3000) begin
            @(negedge clk);
            c++;
        end
        chk("drain_bound", 32'(c < 3000), 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int p0, c;
        total = 0; bad = 0; rnd_rdy = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0; bus.cfg_log2n = 4'd4;
        #2;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_err_len", bus.err_len, 0);
        chk("rst_sram_ce", bus.sram_ce, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // N=16 ramp, then N=256 ramp with continuous output
        send_frame(4'd4, 4'd4, 15, 0);  wait_done();
        send_frame(4'd8, 4'd8, 255, 0); wait_done();
        chk("run256", last_run, 256);

        // N=32 with random backpressure
        rnd_rdy = 1;
        send_frame(4'd5, 4'd5, 31, 1);  wait_done();
        rnd_rdy = 0;

        // misplaced / missing in_last
        send_frame(4'd4, 4'd4, 6, 1);   wait_done();
        send_frame(4'd4, 4'd4, -1, 1);  wait_done();

        // reset during read-out
        send_frame(4'd4, 4'd4, 15, 1);
        p0 = pops; c = 0;
        while (pops - p0 < 5 && c < 200) begin
            @(posedge clk);
            c++;
        end
        chk("rd5_bound", 32'(c < 200), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", bus.out_valid, 0);
        chk("arst_in_ready", bus.in_ready, 1);
        chk("arst_out_last", bus.out_last, 0);
        sbq.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        send_frame(4'd4, 4'd4, 15, 0);  wait_done();

        // out-of-range cfg, mid-frame cfg change, then the new size
        send_frame(4'd12, 4'd12, 255, 1); wait_done();
        send_frame(4'd4, 4'd6, 15, 1);    wait_done();
        send_frame(4'd6, 4'd6, 63, 1);    wait_done();

        @(negedge clk);
        chk("idle_out_valid", bus.out_valid, 0);
        chk("idle_in_ready", bus.in_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
